// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types, size masks and lane helpers
// for the mem_access_unit load/store initiator.
package mem_access_pkg;
  localparam int WORD_BYTES = 4;
  localparam int WORD_BITS  = 8 * WORD_BYTES;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  function automatic logic [3:0] size_mask(mem_size_t s);
    logic [3:0] m;
    unique case (1'b1)
      s == SZ_BYTE: m = MASK_BYTE;
      s == SZ_HALF: m = MASK_HALF;
      s == SZ_WORD: m = MASK_WORD;
      default:      m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic size_err(mem_size_t s, logic [1:0] off);
    logic e;
    unique case (1'b1)
      s == SZ_BYTE: e = 1'b0;
      s == SZ_HALF: e = off[0];
      s == SZ_WORD: e = |off;
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [WORD_BITS-1:0] lane_data(
    mem_size_t              s,
    logic [WORD_BITS-1:0]   d
  );
    logic [WORD_BITS-1:0] r;
    unique case (1'b1)
      s == SZ_BYTE: r = {4{d[7:0]}};
      s == SZ_HALF: r = {2{d[15:0]}};
      default:      r = d;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: core-side request/response handshake
// bundle of mem_access_unit (unit is the slave).
interface mem_access_if #(
  parameter int ADDR_WIDTH = 7
);
  import mem_access_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  mem_size_t             req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [WORD_BITS-1:0]  req_wr_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WORD_BITS-1:0]  resp_rd_data;
  logic                  resp_error;

  modport master (
    output req_valid, req_write, req_size,
    output req_unsigned, req_address, req_wr_data,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rd_data, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_unsigned, req_address, req_wr_data,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rd_data, resp_error
  );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed lane(s) of a memory
// word and sign/zero-extends them to 32 bits.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [WORD_BITS-1:0] mem_rd_data_i,
  input  logic [1:0]           offset_i,
  input  mem_size_t            size_i,
  input  logic                 unsigned_i,
  output logic [WORD_BITS-1:0] result_o
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = mem_rd_data_i[{offset_i, 3'b000} +: 8];
  assign h = offset_i[1] ? mem_rd_data_i[31:16]
                         : mem_rd_data_i[15:0];

  always_comb begin
    result_o = '0;
    unique case (1'b1)
      size_i == SZ_BYTE:
        result_o = {{24{b[7] & ~unsigned_i}}, b};
      size_i == SZ_HALF:
        result_o = {{16{h[15] & ~unsigned_i}}, h};
      size_i == SZ_WORD:
        result_o = mem_rd_data_i;
      default:
        result_o = '0;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for one block-memory port.
// Optional MEM_ACCESS_STATS_EN adds load/store/error counters.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter  int CAPACITY_BYTES = 128,
  localparam int ADDR_WIDTH     = $clog2(CAPACITY_BYTES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_access_if.slave           bus,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rd_en,
  output logic [3:0]            mem_wr_en,
  output logic [WORD_BITS-1:0]  mem_wr_data,
  input  logic [WORD_BITS-1:0]  mem_rd_data
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]           stat_loads,
  output logic [31:0]           stat_stores,
  output logic [31:0]           stat_errors
`endif
);
  state_t    state_q, state_d;
  mem_size_t size_q;
  logic      uns_q, wr_q, err_q;
  logic [1:0] off_q;

  logic       accept, ready, req_bad, resp_valid;
  logic [1:0] off;
  logic [WORD_BITS-1:0] load_data;

  assign off     = bus.req_address[1:0];
  assign req_bad = size_err(bus.req_size, off);
  assign ready   = reset_n &&
                   (state_q == ST_IDLE || bus.resp_ready);
  assign accept  = bus.req_valid && ready;
  assign bus.req_ready = ready;

  // Enables only ever fire on a clean handshake.
  always_comb begin
    state_d     = state_q;
    mem_rd_en   = 1'b0;
    mem_wr_en   = '0;
    mem_address = bus.req_address;
    mem_wr_data = lane_data(bus.req_size, bus.req_wr_data);
    if (accept) begin
      state_d = ST_RESP;
      if (!req_bad) begin
        mem_rd_en = !bus.req_write;
        mem_wr_en = bus.req_write
                  ? size_mask(bus.req_size) << off
                  : 4'b0000;
      end
    end else if (state_q == ST_RESP && bus.resp_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q <= bus.req_size;
        uns_q  <= bus.req_unsigned;
        wr_q   <= bus.req_write;
        err_q  <= req_bad;
        off_q  <= off;
      end
    end
  end

  mem_load_align u_align (
    .mem_rd_data_i (mem_rd_data),
    .offset_i      (off_q),
    .size_i        (size_q),
    .unsigned_i    (uns_q),
    .result_o      (load_data)
  );

  // Read data is live from the port; it holds since rd_en stays low.
  assign resp_valid       = state_q == ST_RESP;
  assign bus.resp_valid   = resp_valid;
  assign bus.resp_error   = resp_valid && err_q;
  assign bus.resp_rd_data = (resp_valid && !wr_q && !err_q)
                          ? load_data : '0;

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] loads_q, stores_q, errors_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      loads_q  <= '0;
      stores_q <= '0;
      errors_q <= '0;
    end else if (accept) begin
      if (req_bad)
        errors_q <= errors_q + 32'd1;
      else if (bus.req_write)
        stores_q <= stores_q + 32'd1;
      else
        loads_q  <= loads_q + 32'd1;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errors = errors_q;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of
// mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int AW = 7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if #(.ADDR_WIDTH(AW)) bus();

  logic [AW-1:0] mem_address;
  logic          mem_rd_en;
  logic [3:0]    mem_wr_en;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0]   stat_loads, stat_stores, stat_errors;
`endif

  mem_access_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .mem_address (mem_address),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errors (stat_errors)
`endif
  );

  // Block memory: registered read, byte write enables.
  logic [31:0] bram [32];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wr_en[i])
        bram[mem_address[6:2]][i*8 +: 8] <= mem_wr_data[i*8 +: 8];
    if (mem_rd_en) mem_rd_data <= bram[mem_address[6:2]];
  end

  typedef struct {
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [7:0] ref_mem [128];
  int checks = 0;
  int errors = 0;
  int n_ld = 0, n_st = 0, n_er = 0;

  function automatic logic [31:0] ref_load(int a, int n, int u);
    longint v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[a+i]) << (8*i);
    if (u == 0 && n < 4 && v >= (longint'(1) << (8*n-1)))
      v -= longint'(1) << (8*n);
    return 32'(v);
  endfunction

  task automatic drive(input int v, input int w, input int sz,
                       input int u, input int a,
                       input logic [31:0] d, input int rr);
    bus.req_valid    = v[0];
    bus.req_write    = w[0];
    bus.req_size     = mem_size_t'(sz[1:0]);
    bus.req_unsigned = u[0];
    bus.req_address  = 7'(a);
    bus.req_wr_data  = d;
    bus.resp_ready   = rr[0];
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    drive(1, 1, 2, 0, 8, 32'h1234_5678, 1);
    repeat (3) tick;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
    checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp_error got %b exp 0", bus.resp_error); end
    checks++; if (mem_wr_en !== 4'b0000) begin errors++; $display("FAIL reset_wr_en got %b exp 0000", mem_wr_en); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", mem_rd_en); end
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", bus.req_ready); end
    tick;
  endtask

  task automatic test_store_word;
    drive(1, 1, 2, 0, 8, 32'hDEAD_BEEF, 1);
    checks++; if (mem_wr_en !== 4'b1111) begin errors++; $display("FAIL sw_wr_en got %b exp 1111", mem_wr_en); end
    checks++; if (mem_wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wr_data got %h exp deadbeef", mem_wr_data); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL sw_rd_en got %b exp 0", mem_rd_en); end
    tick;
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL sw_resp_valid got %b exp 1", bus.resp_valid); end
    checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL sw_resp_error got %b exp 0", bus.resp_error); end
    checks++; if (bus.resp_rd_data !== 32'h0) begin errors++; $display("FAIL sw_resp_data got %h exp 0", bus.resp_rd_data); end
    tick;
  endtask

  task automatic test_byte_and_half;
    int          la [4] = '{13, 13, 14, 12};
    int          ls [4] = '{0, 0, 1, 1};
    int          lu [4] = '{0, 1, 0, 1};
    logic [31:0] le [4] = '{32'hFFFF_FFA5, 32'h0000_00A5,
                            32'hFFFF_8001, 32'h0000_7F00};
    drive(1, 1, 0, 0, 13, 32'h0000_00A5, 1);
    checks++; if (mem_wr_en !== 4'b0010) begin errors++; $display("FAIL sb_wr_en got %b exp 0010", mem_wr_en); end
    checks++; if (mem_wr_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wr_data got %h exp a5a5a5a5", mem_wr_data); end
    tick;
    drive(0, 0, 0, 0, 0, 0, 1);
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        drive(1, 1, 2, 0, 12, 32'h8001_7F00, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 1);
        tick;
      end
      drive(1, 0, ls[i], lu[i], la[i], 0, 1);
      checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL ld%0d_rd_en got %b exp 1", i, mem_rd_en); end
      tick;
      drive(0, 0, 0, 0, 0, 0, 1);
      checks++; if (bus.resp_rd_data !== le[i]) begin errors++; $display("FAIL ld%0d_data got %h exp %h", i, bus.resp_rd_data, le[i]); end
      tick;
    end
  endtask

  task automatic test_errors;
    int ew [4] = '{0, 0, 1, 1};
    int es [4] = '{2, 3, 3, 1};
    int ea [4] = '{6, 0, 4, 5};
    for (int i = 0; i < 4; i++) begin
      drive(1, ew[i], es[i], 0, ea[i], 32'hFFFF_FFFF, 1);
      checks++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 4'b0) begin errors++; $display("FAIL err%0d_enables got %b/%b exp 0/0000", i, mem_rd_en, mem_wr_en); end
      tick;
      drive(0, 0, 0, 0, 0, 0, 1);
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b1) begin errors++; $display("FAIL err%0d_resp got v%b e%b exp v1 e1", i, bus.resp_valid, bus.resp_error); end
      checks++; if (bus.resp_rd_data !== 32'h0) begin errors++; $display("FAIL err%0d_data got %h exp 0", i, bus.resp_rd_data); end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int          ba [4] = '{8, 12, 13, 14};
    int          bs [4] = '{2, 2, 0, 1};
    int          bu [4] = '{0, 0, 1, 0};
    logic [31:0] be [4] = '{32'hDEAD_BEEF, 32'h8001_7F00,
                            32'h0000_007F, 32'hFFFF_8001};
    logic [31:0] prev;
    drive(1, 0, 2, 0, 8, 0, 1);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 2, 0, 12, 0, 0);
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_ready got %b exp 0", i, bus.req_ready); end
      checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL bp%0d_rd_en got %b exp 0", i, mem_rd_en); end
      checks++; if (bus.resp_rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp%0d_data got %h exp deadbeef", i, bus.resp_rd_data); end
      tick;
    end
    prev = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, bs[i], bu[i], ba[i], 0, 1);
      checks++; if (bus.req_ready !== 1'b1 || mem_rd_en !== 1'b1) begin errors++; $display("FAIL b2b%0d_accept got r%b rd%b exp 1/1", i, bus.req_ready, mem_rd_en); end
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rd_data !== prev) begin errors++; $display("FAIL b2b%0d_resp got v%b %h exp v1 %h", i, bus.resp_valid, bus.resp_rd_data, prev); end
      prev = be[i];
      tick;
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rd_data !== prev) begin errors++; $display("FAIL b2b_last got v%b %h exp v1 %h", bus.resp_valid, bus.resp_rd_data, prev); end
    tick;
  endtask

  task automatic test_reset_midop;
    drive(1, 0, 2, 0, 8, 0, 0);
    tick;
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got %b exp 1", bus.resp_valid); end
    reset_n = 1'b0;
    drive(1, 1, 2, 0, 0, 32'h1111_2222, 0);
    checks++; if (bus.req_ready !== 1'b0 || mem_wr_en !== 4'b0 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL mid_enables got r%b w%b rd%b exp 0", bus.req_ready, mem_wr_en, mem_rd_en); end
    tick;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_dropped got %b exp 0", bus.resp_valid); end
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b exp 1", bus.req_ready); end
`ifdef MEM_ACCESS_STATS_EN
    checks++; if ({stat_loads, stat_stores, stat_errors} !== 96'h0) begin errors++; $display("FAIL mid_stats got %0d %0d %0d exp 0", stat_loads, stat_stores, stat_errors); end
`endif
    tick;
  endtask

  task automatic test_fill;
    for (int w = 0; w < 32; w++) begin
      logic [31:0] d;
      d = $urandom;
      drive(1, 1, 2, 0, w*4, d, 1);
      for (int i = 0; i < 4; i++) ref_mem[w*4+i] = d[i*8 +: 8];
      n_st++;
      tick;
      drive(0, 0, 0, 0, 0, 0, 1);
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b0) begin errors++; $display("FAIL fill%0d got v%b e%b exp v1 e0", w, bus.resp_valid, bus.resp_error); end
      tick;
    end
  endtask

  task automatic test_random;
    resp_t q[$];
    for (int c = 0; c < 420; c++) begin
      int v, w, u, rr, sz, a, n;
      bit err, exp_ready, acc;
      logic [31:0] d, exp_wd;
      logic [3:0]  exp_en;
      resp_t r;
      v  = ($urandom_range(9) < 7) ? 1 : 0;
      rr = ($urandom_range(9) < 7) ? 1 : 0;
      if (c >= 400) begin v = 0; rr = 1; end
      w  = $urandom_range(1);
      u  = $urandom_range(1);
      sz = $urandom_range(3);
      a  = $urandom_range(127);
      d  = $urandom;
      drive(v, w, sz, u, a, d, rr);
      checks++; if (bus.resp_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd%0d_resp_valid got %b exp %0d", c, bus.resp_valid, q.size()); end
      if (q.size() != 0) begin
        checks++; if (bus.resp_error !== q[0].err || bus.resp_rd_data !== q[0].data) begin errors++; $display("FAIL rnd%0d_resp got e%b %h exp e%b %h", c, bus.resp_error, bus.resp_rd_data, q[0].err, q[0].data); end
      end
      exp_ready = (q.size() == 0) || (rr != 0);
      checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rnd%0d_ready got %b exp %b", c, bus.req_ready, exp_ready); end
      n   = 1 << sz;
      err = (sz == 3) || (a % n != 0);
      acc = (v != 0) && exp_ready;
      exp_en = '0;
      exp_wd = '0;
      for (int i = 0; i < 4; i++) begin
        exp_en[i] = acc && w != 0 && !err && i >= a % 4 && i < a % 4 + n;
        exp_wd[i*8 +: 8] = d[8*(i % n) +: 8];
      end
      checks++; if (mem_rd_en !== (acc && w == 0 && !err) || mem_wr_en !== exp_en) begin errors++; $display("FAIL rnd%0d_enables got rd%b w%b exp rd%b w%b", c, mem_rd_en, mem_wr_en, acc && w == 0 && !err, exp_en); end
      if (exp_en != 0) begin
        checks++; if (mem_wr_data !== exp_wd) begin errors++; $display("FAIL rnd%0d_wr_data got %h exp %h", c, mem_wr_data, exp_wd); end
      end
      if (q.size() != 0 && rr != 0) void'(q.pop_front());
      if (acc) begin
        r.err  = err;
        r.data = (err || w != 0) ? 32'h0 : ref_load(a, n, u);
        q.push_back(r);
        if (err) n_er++;
        else if (w != 0) begin
          n_st++;
          for (int i = 0; i < n; i++) ref_mem[a+i] = d[8*i +: 8];
        end else n_ld++;
      end
      tick;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending exp 0", q.size()); end
`ifdef MEM_ACCESS_STATS_EN
    checks++; if (stat_loads !== 32'(n_ld) || stat_stores !== 32'(n_st) || stat_errors !== 32'(n_er)) begin errors++; $display("FAIL stats got %0d %0d %0d exp %0d %0d %0d", stat_loads, stat_stores, stat_errors, n_ld, n_st, n_er); end
`endif
  endtask

  initial begin
    test_reset;
    test_store_word;
    test_byte_and_half;
    test_errors;
    test_back_to_back;
    test_reset_midop;
    test_fill;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
